// File: rtl/wb_regfile_pkg.sv
// Shared widths, constants and the WB-stage bundle
// for the writeback stage and integer register file.
package wb_regfile_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_NUM        = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [DATA_WIDTH-1:0]     data_t;
  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;

  localparam data_t ZERO          = '0;
  localparam logic  WRITE_ENABLE  = 1'b1;
  localparam logic  WRITE_DISABLE = 1'b0;
  localparam addr_t ZERO_REG      = 5'd0;

  typedef struct packed {
    logic  valid;
    logic  we;
    addr_t waddr;
    data_t wdata;
  } wb_t;

  localparam wb_t WB_BUBBLE = '{
    valid: 1'b0,
    we:    WRITE_DISABLE,
    waddr: ZERO_REG,
    wdata: ZERO
  };

  // x0 and reset force zero; a committing WB entry wins over the array
  function automatic data_t rd_sel(
    input logic  rst,
    input addr_t raddr,
    input wb_t   wb,
    input data_t arr
  );
    data_t r;
    if (rst || raddr == ZERO_REG)
      r = ZERO;
    else if (wb.valid && wb.we && wb.waddr == raddr)
      r = wb.wdata;
    else
      r = arr;
    return r;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// EX-to-WB result bundle, pipeline control,
// operand read ports and WB trace tap.
interface wb_regfile_if
  import wb_regfile_pkg::*;
  ();

  logic  ex_valid_i;
  logic  ex_we_i;
  addr_t ex_waddr_i;
  data_t ex_wdata_i;
  logic  stall_i;
  logic  flush_i;
  addr_t raddr1_i;
  addr_t raddr2_i;
  data_t rdata1_o;
  data_t rdata2_o;
  logic  wb_valid_o;
  logic  wb_we_o;
  addr_t wb_waddr_o;
  data_t wb_wdata_o;

  modport master (
    output ex_valid_i, ex_we_i,
    output ex_waddr_i, ex_wdata_i,
    output stall_i, flush_i,
    output raddr1_i, raddr2_i,
    input  rdata1_o, rdata2_o,
    input  wb_valid_o, wb_we_o,
    input  wb_waddr_o, wb_wdata_o
  );

  modport slave (
    input  ex_valid_i, ex_we_i,
    input  ex_waddr_i, ex_wdata_i,
    input  stall_i, flush_i,
    input  raddr1_i, raddr2_i,
    output rdata1_o, rdata2_o,
    output wb_valid_o, wb_we_o,
    output wb_waddr_o, wb_wdata_o
  );

endinterface

// File: rtl/wb_regfile_array.sv
// 32-entry register storage: one sync write port with
// sync clear, two raw combinational read ports.
module wb_regfile_array
  import wb_regfile_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  we_i,
  input  addr_t waddr_i,
  input  data_t wdata_i,
  input  addr_t raddr1_i,
  input  addr_t raddr2_i,
  output data_t rdata1_o,
  output data_t rdata2_o
);

  data_t mem_q [REG_NUM];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_NUM; i++)
        mem_q[i] <= ZERO;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: one-entry WB register, array commit,
// WB bypass onto both operand read ports, x0 hardwired.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input logic         clk_i,
  input logic         rst_i,
  wb_regfile_if.slave bus
);

  wb_t   wb_q;
  wb_t   wb_d;
  logic  commit;
  data_t arr1;
  data_t arr2;

  always_comb begin
    wb_d = wb_q;
    if (bus.flush_i) begin
      wb_d = WB_BUBBLE;
    end else if (!bus.stall_i) begin
      wb_d.valid = bus.ex_valid_i;
      wb_d.we    = bus.ex_valid_i
                 & bus.ex_we_i
                 & (bus.ex_waddr_i != ZERO_REG);
      wb_d.waddr = bus.ex_waddr_i;
      wb_d.wdata = bus.ex_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      wb_q <= WB_BUBBLE;
    else
      wb_q <= wb_d;
  end

  // commit ignores stall/flush: WB contents always retire
  assign commit = wb_q.valid & wb_q.we;

  wb_regfile_array u_array (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (commit),
    .waddr_i  (wb_q.waddr),
    .wdata_i  (wb_q.wdata),
    .raddr1_i (bus.raddr1_i),
    .raddr2_i (bus.raddr2_i),
    .rdata1_o (arr1),
    .rdata2_o (arr2)
  );

  assign bus.rdata1_o =
    rd_sel(rst_i, bus.raddr1_i, wb_q, arr1);
  assign bus.rdata2_o =
    rd_sel(rst_i, bus.raddr2_i, wb_q, arr2);

  assign bus.wb_valid_o = wb_q.valid;
  assign bus.wb_we_o    = wb_q.we;
  assign bus.wb_waddr_o = wb_q.waddr;
  assign bus.wb_wdata_o = wb_q.wdata;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table,
// reset corner sequences and a randomized model run.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        r, f, s, v, we;
    logic [4:0]  rd, ra1, ra2;
    logic [31:0] data;
    logic [31:0] e1, e2;
    logic        ev, ewe;
  } vec_t;

  vec_t tbl[$];

  int nvec = 0;
  int nerr = 0;

  // architectural view: a register takes its new value
  // the moment the writing instruction enters WB
  logic [31:0] arch [32];
  logic        m_v, m_we;
  logic [4:0]  m_a;
  logic [31:0] m_d;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic drive(input logic r, f, s, v, we,
                       input logic [4:0] rd, ra1, ra2,
                       input logic [31:0] d);
    rst            = r;
    bus.flush_i    = f;
    bus.stall_i    = s;
    bus.ex_valid_i = v;
    bus.ex_we_i    = we;
    bus.ex_waddr_i = rd;
    bus.ex_wdata_i = d;
    bus.raddr1_i   = ra1;
    bus.raddr2_i   = ra2;
  endtask

  function automatic logic [31:0] exp_rd(
    input logic [4:0] ra);
    if (rst || ra == 5'd0) return 32'h0;
    return arch[ra];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) arch[i] = 32'h0;
      {m_v, m_we, m_a, m_d} = '0;
    end else if (bus.flush_i) begin
      {m_v, m_we, m_a, m_d} = '0;
    end else if (!bus.stall_i) begin
      m_v  = bus.ex_valid_i;
      m_we = bus.ex_valid_i && bus.ex_we_i
          && bus.ex_waddr_i != 5'd0;
      m_a  = bus.ex_waddr_i;
      m_d  = bus.ex_wdata_i;
      if (m_we) arch[m_a] = m_d;
    end
    #1;
  endtask

  task automatic add(input logic r, f, s, v, we,
                     input logic [4:0] rd, ra1, ra2,
                     input logic [31:0] d, e1, e2,
                     input logic ev, ewe);
    vec_t t;
    t.r = r; t.f = f; t.s = s; t.v = v; t.we = we;
    t.rd = rd; t.ra1 = ra1; t.ra2 = ra2; t.data = d;
    t.e1 = e1; t.e2 = e2; t.ev = ev; t.ewe = ewe;
    tbl.push_back(t);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) arch[i] = 32'h0;
    {m_v, m_we, m_a, m_d} = '0;

    // reset, then sweep x1..x31 on both ports
    tick();
    chk("rst_wb_valid", {31'b0, bus.wb_valid_o}, 0);
    chk("rst_wb_we", {31'b0, bus.wb_we_o}, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int r = 1; r < 32; r++) begin
      bus.raddr1_i = 5'(r);
      bus.raddr2_i = 5'(32 - r);
      #1;
      chk("sweep_rd1", bus.rdata1_o, 0);
      chk("sweep_rd2", bus.rdata2_o, 0);
    end

    add(0,0,0,1,1, 5,5,0,  32'hA5, 32'hA5,0, 1,1);
    add(0,0,0,0,0, 0,5,5,  0, 32'hA5,32'hA5, 0,0);
    add(0,0,0,0,0, 0,5,0,  0, 32'hA5,0, 0,0);
    add(0,0,0,1,1, 0,0,0,  32'hDEADBEEF, 0,0, 1,0);
    add(0,0,0,0,0, 0,0,0,  0, 0,0, 0,0);
    add(0,0,0,1,1, 7,7,5,  32'h11111111,
        32'h11111111,32'hA5, 1,1);
    for (int k = 0; k < 3; k++)
      add(0,0,1,1,1, 7,7,7, 32'h22222222,
          32'h11111111,32'h11111111, 1,1);
    add(0,0,0,1,1, 7,7,7,  32'h22222222,
        32'h22222222,32'h22222222, 1,1);
    add(0,0,0,0,0, 0,7,0,  0, 32'h22222222,0, 0,0);
    add(0,1,1,1,1, 9,9,7,  32'h5, 0,32'h22222222, 0,0);
    add(0,0,0,0,0, 0,9,0,  0, 0,0, 0,0);
    add(0,0,0,1,1, 3,3,7,  32'h77, 32'h77,32'h22222222, 1,1);
    add(1,0,0,0,0, 0,3,7,  0, 0,0, 0,0);
    add(0,0,0,0,0, 0,3,7,  0, 0,0, 0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].v,
            tbl[i].we, tbl[i].rd, tbl[i].ra1,
            tbl[i].ra2, tbl[i].data);
      #1;
      if (tbl[i].r) begin
        chk("rst_comb_rd1", bus.rdata1_o, 0);
        chk("rst_comb_rd2", bus.rdata2_o, 0);
      end
      tick();
      chk("tbl_rd1", bus.rdata1_o, tbl[i].e1);
      chk("tbl_rd2", bus.rdata2_o, tbl[i].e2);
      chk("tbl_wb_valid", {31'b0, bus.wb_valid_o},
          {31'b0, tbl[i].ev});
      chk("tbl_wb_we", {31'b0, bus.wb_we_o},
          {31'b0, tbl[i].ewe});
    end

    // write-disabled result occupies WB but never bypasses
    drive(0, 0, 0, 1, 1, 4, 4, 4, 32'hCAFE0004);
    tick();
    drive(0, 0, 0, 1, 0, 4, 4, 4, 32'h0BAD0BAD);
    tick();
    chk("nowe_wb_valid", {31'b0, bus.wb_valid_o}, 1);
    chk("nowe_wb_we", {31'b0, bus.wb_we_o}, 0);
    chk("nowe_rd1", bus.rdata1_o, 32'hCAFE0004);
    drive(0, 0, 0, 0, 0, 0, 4, 0, 0);
    tick();
    chk("nowe_arr", bus.rdata1_o, 32'hCAFE0004);

    // randomized run against the model
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 39) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) != 0,
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)),
            $urandom);
      tick();
      chk("rnd_rd1", bus.rdata1_o, exp_rd(bus.raddr1_i));
      chk("rnd_rd2", bus.rdata2_o, exp_rd(bus.raddr2_i));
      chk("rnd_wb_valid", {31'b0, bus.wb_valid_o},
          {31'b0, m_v});
      chk("rnd_wb_we", {31'b0, bus.wb_we_o},
          {31'b0, m_we});
      chk("rnd_wb_waddr", {27'b0, bus.wb_waddr_o},
          {27'b0, m_a});
      chk("rnd_wb_wdata", bus.wb_wdata_o, m_d);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
